pipemem: RTL and testbench

PIPEMEM -- requirements
Module: pipemem

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipemem_if.sv | 36 +++
 rtl/pipereg_en.sv | 34 +++
 rtl/pipemem.sv | 154 +++++++++++++++
 tb/tb_pipemem.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the memory stage of the pipeline.
// Contents:
//   M_IDLE, M_WAIT - memory-stage FSM state encodings
//   WD_LIMIT       - watchdog threshold in consecutive un-acked wait cycles
//   exmem_t        - EX/MEM pipeline register payload
//   memwb_t        - MEM/WB pipeline register payload
package pipe_pkg;

    localparam logic M_IDLE = 1'b0;
    localparam logic M_WAIT = 1'b1;

    localparam logic [7:0] WD_LIMIT = 8'd255;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
    } exmem_t;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [31:0] mo;
        logic [31:0] alu;
        logic [4:0]  rn;
    } memwb_t;

endpackage

// File: rtl/pipemem_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// Signals:
//   dmem_req   - access in progress (master -> slave)
//   dmem_we    - access is a store (master -> slave)
//   dmem_addr  - byte address (master -> slave)
//   dmem_wdata - store data (master -> slave)
//   dmem_rdata - load data, valid with dmem_ack (slave -> master)
//   dmem_ack   - access completion strobe (slave -> master)
interface pipemem_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );

endinterface

// File: rtl/pipereg_en.sv
// Generic pipeline register with load enable, bubble insertion and asynchronous clear.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low clear (register -> 0)
//   i_en     - load i_d on the next edge
//   i_bubble - load all-zero on the next edge; overrides i_en
//   i_d      - next value
//   o_q      - current value
module pipereg_en #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_bubble,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    logic [Width-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_bubble) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipemem.sv
// Memory stage of a five-stage pipeline: EX/MEM register, data-memory handshake FSM,
// MEM/WB register, pipeline freeze request and a sticky watchdog on slow memory.
// Ports:
//   clock, resetn            - rising-edge clock, asynchronous active-low reset
//   ewreg/em2reg/ewmem       - EX-stage control (register write, load, store)
//   ealu, eb, ern            - EX-stage ALU result/address, store data, destination
//   dmem                     - data-memory bus (master side)
//   mwreg/mm2reg/mwmem/malu/mb/mrn - EX/MEM register contents
//   wwreg/wm2reg/wmo/walu/wrn      - MEM/WB register contents
//   mem_stall                - freeze request for PC, IF/ID, ID/EX and EX
//   mem_err                  - sticky watchdog error
module pipemem
    import pipe_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic             ewmem,
    input  logic [31:0]      ealu,
    input  logic [31:0]      eb,
    input  logic [4:0]       ern,
    pipemem_if.master        dmem,
    output logic             mwreg,
    output logic             mm2reg,
    output logic             mwmem,
    output logic [31:0]      malu,
    output logic [31:0]      mb,
    output logic [4:0]       mrn,
    output logic             wwreg,
    output logic             wm2reg,
    output logic [31:0]      wmo,
    output logic [31:0]      walu,
    output logic [4:0]       wrn,
    output logic             mem_stall,
    output logic             mem_err
);

    logic       r_state;
    logic       w_state_d;
    logic [7:0] r_wd_cnt;
    logic [7:0] w_wd_cnt_d;
    logic       r_mem_err;
    logic       w_memop;
    logic       w_in_wait;
    logic       w_em_en;
    exmem_t     w_em_d;
    exmem_t     w_em_q;
    memwb_t     w_mw_d;
    memwb_t     w_mw_q;

    // EX/MEM register: frozen while the stage is stalled
    always_comb begin
        w_em_d       = '0;
        w_em_d.wreg  = ewreg;
        w_em_d.m2reg = em2reg;
        w_em_d.wmem  = ewmem;
        w_em_d.alu   = ealu;
        w_em_d.b     = eb;
        w_em_d.rn    = ern;
    end

    assign w_em_en = ~mem_stall;

    pipereg_en #(
        .Width ($bits(exmem_t))
    ) u_exmem (
        .clk      (clock),
        .rst_n    (resetn),
        .i_en     (w_em_en),
        .i_bubble (1'b0),
        .i_d      (w_em_d),
        .o_q      (w_em_q)
    );

    assign w_memop   = w_em_q.m2reg | w_em_q.wmem;
    assign w_in_wait = (r_state == M_WAIT);

    // Handshake FSM; ack only matters in M_WAIT
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            M_IDLE:  if (w_memop)       w_state_d = M_WAIT;
            M_WAIT:  if (dmem.dmem_ack) w_state_d = M_IDLE;
            default: w_state_d = M_IDLE;
        endcase
    end

    // The first stall cycle is spent in M_IDLE launching the access, so every memop
    // costs one cycle even against a zero-wait memory.
    assign mem_stall = (~w_in_wait & w_memop) | (w_in_wait & ~dmem.dmem_ack);

    // Watchdog: saturates at WD_LIMIT so it cannot wrap during a very long wait
    always_comb begin
        w_wd_cnt_d = '0;
        if (w_in_wait && !dmem.dmem_ack) begin
            w_wd_cnt_d = (r_wd_cnt == WD_LIMIT) ? r_wd_cnt : r_wd_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= M_IDLE;
            r_wd_cnt  <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_wd_cnt  <= w_wd_cnt_d;
            r_mem_err <= r_mem_err | (w_wd_cnt_d == WD_LIMIT);
        end
    end

    // Address/data come straight from the frozen EX/MEM register, so they stay
    // stable for the whole wait interval.
    assign dmem.dmem_req   = w_in_wait;
    assign dmem.dmem_we    = w_in_wait & w_em_q.wmem;
    assign dmem.dmem_addr  = w_em_q.alu;
    assign dmem.dmem_wdata = w_em_q.b;

    // MEM/WB register: a stalled edge writes a bubble
    always_comb begin
        w_mw_d       = '0;
        w_mw_d.wreg  = w_em_q.wreg;
        w_mw_d.m2reg = w_em_q.m2reg;
        w_mw_d.mo    = dmem.dmem_rdata;
        w_mw_d.alu   = w_em_q.alu;
        w_mw_d.rn    = w_em_q.rn;
    end

    pipereg_en #(
        .Width ($bits(memwb_t))
    ) u_memwb (
        .clk      (clock),
        .rst_n    (resetn),
        .i_en     (1'b1),
        .i_bubble (mem_stall),
        .i_d      (w_mw_d),
        .o_q      (w_mw_q)
    );

    assign mwreg   = w_em_q.wreg;
    assign mm2reg  = w_em_q.m2reg;
    assign mwmem   = w_em_q.wmem;
    assign malu    = w_em_q.alu;
    assign mb      = w_em_q.b;
    assign mrn     = w_em_q.rn;
    assign wwreg   = w_mw_q.wreg;
    assign wm2reg  = w_mw_q.m2reg;
    assign wmo     = w_mw_q.mo;
    assign walu    = w_mw_q.alu;
    assign wrn     = w_mw_q.rn;
    assign mem_err = r_mem_err;

endmodule

// File: tb/tb_pipemem.sv
// Self-checking bench for pipemem: an instruction stream with per-memop memory latency
// is played through the stage; a transaction-level model predicts stall length
// (1 + wait cycles), the bus, both pipeline registers and the watchdog flag.
module tb_pipemem;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
        logic [9:0]  lat;   // wait cycles without ack before the acking cycle
    } ins_t;

    logic        clock = 1'b0;
    logic        resetn;
    logic        ewreg, em2reg, ewmem;
    logic [31:0] ealu, eb;
    logic [4:0]  ern;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        wwreg, wm2reg;
    logic [31:0] wmo, walu;
    logic [4:0]  wrn;
    logic        mem_stall, mem_err;

    pipemem_if u_if ();

    pipemem u_dut (
        .clock     (clock),
        .resetn    (resetn),
        .ewreg     (ewreg),
        .em2reg    (em2reg),
        .ewmem     (ewmem),
        .ealu      (ealu),
        .eb        (eb),
        .ern       (ern),
        .dmem      (u_if),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mwmem     (mwmem),
        .malu      (malu),
        .mb        (mb),
        .mrn       (mrn),
        .wwreg     (wwreg),
        .wm2reg    (wm2reg),
        .wmo       (wmo),
        .walu      (walu),
        .wrn       (wrn),
        .mem_stall (mem_stall),
        .mem_err   (mem_err)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    ins_t        prog[$];
    ins_t        cur;          // instruction held in EX/MEM
    int          k;            // stall cycles already spent on cur
    logic        model_err;
    int          force_ack;
    logic        wb_wreg, wb_m2reg, wb_valid, wb_load;
    logic [31:0] wb_alu, wb_mo;
    logic [4:0]  wb_rn;
    logic [31:0] mem_model [logic [31:0]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic ins_t mk_ins(input logic wreg, input logic m2reg, input logic wmem,
                                    input logic [31:0] alu, input logic [31:0] b,
                                    input logic [4:0] rn, input logic [9:0] lat);
        ins_t t;
        t.wreg  = wreg;
        t.m2reg = m2reg;
        t.wmem  = wmem;
        t.alu   = alu;
        t.b     = b;
        t.rn    = rn;
        t.lat   = lat;
        return t;
    endfunction

    function automatic ins_t rand_ins();
        int          kind;
        logic [31:0] addr;
        logic [9:0]  lat;
        kind = $urandom_range(0, 3);
        addr = 32'($urandom_range(0, 7)) << 2;
        lat  = 10'($urandom_range(0, 3));
        case (kind)
            0:       return mk_ins(1'b1, 1'b0, 1'b0, $urandom, $urandom, 5'($urandom), 10'd0);
            1:       return mk_ins(1'b1, 1'b1, 1'b0, addr, $urandom, 5'($urandom), lat);
            2:       return mk_ins(1'b0, 1'b0, 1'b1, addr, $urandom, 5'($urandom), lat);
            default: return mk_ins(1'b0, 1'b0, 1'b0, $urandom, $urandom, 5'($urandom), 10'd0);
        endcase
    endfunction

    task automatic model_reset();
        cur       = '0;
        k         = 0;
        model_err = 1'b0;
        wb_wreg   = 1'b0;
        wb_m2reg  = 1'b0;
        wb_valid  = 1'b1;
        wb_load   = 1'b1;
        wb_alu    = '0;
        wb_mo     = '0;
        wb_rn     = '0;
    endtask

    task automatic check_outputs(input logic exp_stall, input logic exp_req);
        check_eq("mem_stall", mem_stall, exp_stall);
        check_eq("dmem_req", u_if.dmem_req, exp_req);
        check_eq("dmem_we", u_if.dmem_we, exp_req & cur.wmem);
        if (exp_req) begin
            check_eq("dmem_addr", u_if.dmem_addr, cur.alu);
            check_eq("dmem_wdata", u_if.dmem_wdata, cur.b);
        end
        check_eq("mwreg", mwreg, cur.wreg);
        check_eq("mm2reg", mm2reg, cur.m2reg);
        check_eq("mwmem", mwmem, cur.wmem);
        check_eq("malu", malu, cur.alu);
        check_eq("mb", mb, cur.b);
        check_eq("mrn", mrn, cur.rn);
        check_eq("wwreg", wwreg, wb_wreg);
        check_eq("wm2reg", wm2reg, wb_m2reg);
        if (wb_valid) begin
            check_eq("wrn", wrn, wb_rn);
            check_eq("walu", walu, wb_alu);
        end
        if (wb_load) check_eq("wmo", wmo, wb_mo);
        check_eq("mem_err", mem_err, model_err);
    endtask

    // One clock cycle: drive at negedge, check 2 ns later, advance the model at posedge.
    task automatic step();
        ins_t nx;
        logic memop, exp_stall, exp_req, ack_now;
        int   w;
        @(negedge clock);
        if (prog.size() == 0) prog.push_back(rand_ins());
        nx     = prog[0];
        ewreg  = nx.wreg;
        em2reg = nx.m2reg;
        ewmem  = nx.wmem;
        ealu   = nx.alu;
        eb     = nx.b;
        ern    = nx.rn;

        memop     = cur.m2reg | cur.wmem;
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        ack_now   = 1'b0;
        if (memop) begin
            if (k == 0) begin
                exp_stall = 1'b1;
            end else begin
                w         = k - 1;
                exp_req   = 1'b1;
                ack_now   = (w == int'(cur.lat));
                exp_stall = !ack_now;
                if (w >= 255) model_err = 1'b1;
            end
        end
        if (exp_req) u_if.dmem_ack = ack_now;
        else         u_if.dmem_ack = (force_ack > 0) ? 1'b1 : 1'($urandom_range(0, 1));
        u_if.dmem_rdata = ack_now ? mem_rd(cur.alu) : $urandom;
        if (force_ack > 0) force_ack--;

        #2;
        check_outputs(exp_stall, exp_req);

        @(posedge clock);
        if (exp_stall) begin
            k++;
            wb_wreg  = 1'b0;
            wb_m2reg = 1'b0;
            wb_valid = 1'b0;
            wb_load  = 1'b0;
        end else begin
            wb_wreg  = cur.wreg;
            wb_m2reg = cur.m2reg;
            wb_rn    = cur.rn;
            wb_alu   = cur.alu;
            wb_valid = 1'b1;
            wb_load  = cur.m2reg;
            wb_mo    = mem_rd(cur.alu);
            if (cur.wmem) mem_model[cur.alu] = cur.b;
            cur = nx;
            void'(prog.pop_front());
            k = 0;
        end
    endtask

    initial begin
        resetn          = 1'b0;
        ewreg           = 1'b0;
        em2reg          = 1'b0;
        ewmem           = 1'b0;
        ealu            = '0;
        eb              = '0;
        ern             = '0;
        u_if.dmem_ack   = 1'b0;
        u_if.dmem_rdata = '0;
        force_ack       = 0;
        model_reset();

        // Reset state
        #2;
        check_outputs(1'b0, 1'b0);
        @(negedge clock);
        #2 resetn = 1'b1;

        // Directed: ALU op, zero-wait load, 3-wait store, two back-to-back loads
        mem_model[32'h100] = 32'hDEAD_BEEF;
        prog.push_back(mk_ins(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd3, 10'd0));
        prog.push_back(mk_ins(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd5, 10'd0));
        prog.push_back(mk_ins(1'b0, 1'b0, 1'b1, 32'h200, 32'h1234, 5'd0, 10'd3));
        prog.push_back(mk_ins(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd6, 10'd0));
        prog.push_back(mk_ins(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd7, 10'd0));
        prog.push_back(mk_ins(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 10'd0));
        while (prog.size() > 1) step();

        // Random instruction mix
        repeat (300) step();

        // Reset in the middle of a wait; the next load must ignore a stray ack in M_IDLE
        prog.push_back(mk_ins(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd9, 10'd6));
        prog.push_back(mk_ins(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd10, 10'd0));
        for (int i = 0; i < 200 && !(cur.m2reg && cur.lat == 10'd6 && k >= 3); i++) step();
        check_eq("mid_wait_reached", 32'(k >= 3), 32'd1);
        @(negedge clock);
        #1 resetn = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b0, 1'b0);
        @(posedge clock);
        #2 resetn = 1'b1;
        force_ack = 3;
        repeat (6) step();

        // Watchdog: ack withheld for 300 wait cycles
        prog.push_back(mk_ins(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 5'd12, 10'd300));
        repeat (330) step();
        check_eq("mem_err_sticky", mem_err, 1'b1);
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
